// File: rtl/channel_pack_6.sv
// ============================================================================
// channel_pack_6
// ----------------------------------------------------------------------------
// Serial-to-parallel packer for six per-channel convolution results.
//
// The convolution engine hands over one channel result per transfer, in
// channel order 0..5. This block gathers six of them and presents them as one
// packed bus to the six-input channel adder tree (add_channel_6).
//
// There are two buffers:
//   - a collect buffer (six slots plus a channel counter), filled word by word
//   - an output register (conv / out_valid), which holds one complete group
//     for the downstream consumer
// Because of this split, a new group can be collected while the previous
// group is still waiting to be taken downstream.
//
// Optional feature macro: CHAN_LAST_CHECK_EN
//   When it is defined, in_last is checked against the channel counter and
//   framing problems set the sticky err flag. When it is undefined, in_last
//   is ignored and err is tied to 0.
//
// Parameters
//   BIT_WIDTH  width of one two's-complement channel result (default 8)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   upstream word is valid
//   in_ready   block accepts a word when in_valid && in_ready
//   in_data    channel result, channels arrive in order 0..5
//   in_last    marks channel 5 of a group (checked only with the macro)
//   out_valid  conv holds a complete group
//   out_ready  downstream takes the group when out_valid && out_ready
//   conv       packed group, channel k at conv[(k+1)*BIT_WIDTH-1 : k*BIT_WIDTH]
//   err        sticky framing error flag
// ============================================================================
module channel_pack_6 #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BIT_WIDTH-1:0]   in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [6*BIT_WIDTH-1:0] conv,
    output logic                   err
);

    localparam int NUM_CHAN = 6;

    // FILL: the collect buffer is taking words.
    // HOLD: a complete group sits in the collect buffer and waits for the
    //       output register to become free.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0]     slot_q [NUM_CHAN];
    logic [BIT_WIDTH-1:0]     slot_d [NUM_CHAN];
    logic [6*BIT_WIDTH-1:0]   conv_q, conv_d;
    logic                     outValid_q, outValid_d;
    logic                     inReady_q, inReady_d;
    logic                     err_q, err_d;

    logic                     accept;
    logic                     outFire;
    logic                     sixthWord;
    logic                     frameBreak;
    logic                     missingLast;

    // Handshake decodes shared by the next-state logic. in_ready comes from a
    // register, so accept never depends combinationally on out_ready.
    assign accept    = in_valid && inReady_q;
    assign outFire   = outValid_q && out_ready;
    assign sixthWord = (cnt_q == 3'd5);

`ifdef CHAN_LAST_CHECK_EN
    // An early in_last breaks the frame: the partial group is thrown away.
    // A missing in_last on channel 5 is only flagged, and the group is still
    // emitted because its six words are all present.
    assign frameBreak  = accept && in_last && !sixthWord;
    assign missingLast = accept && !in_last && sixthWord;
`else
    // Without the framing check, in_last has no effect. The tap below only
    // marks the input as intentionally unused.
    logic unusedLast;
    assign unusedLast  = in_last;
    assign frameBreak  = 1'b0;
    assign missingLast = 1'b0;
`endif

    // Next-state logic for the packer.
    // In FILL, each accepted word goes into slot cnt. The sixth word either
    // goes straight into the output register together with slots 0..4 (when
    // the output is free this cycle), or it parks in slot 5 and the FSM moves
    // to HOLD. In HOLD, the parked group moves to the output register as soon
    // as the current one drains. Because the free test includes out_ready, a
    // drain and a sixth-word accept on the same edge give back-to-back groups
    // with no bubble. in_ready for the next cycle is just the decode of the
    // next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        slot_d      = slot_q;
        conv_d      = conv_q;
        outValid_d  = outValid_q;
        err_d       = err_q;

        if (outFire) begin
            outValid_d = 1'b0;
        end

        case (state_q)
            FILL: begin
                if (accept) begin
                    if (frameBreak) begin
                        cnt_d = 3'd0;
                    end else if (sixthWord) begin
                        cnt_d = 3'd0;
                        if (!outValid_q || out_ready) begin
                            for (int k = 0; k < NUM_CHAN - 1; k++) begin
                                conv_d[k*BIT_WIDTH +: BIT_WIDTH] = slot_q[k];
                            end
                            conv_d[(NUM_CHAN-1)*BIT_WIDTH +: BIT_WIDTH] = in_data;
                            outValid_d = 1'b1;
                        end else begin
                            slot_d[NUM_CHAN-1] = in_data;
                            state_d            = HOLD;
                        end
                    end else begin
                        slot_d[cnt_q] = in_data;
                        cnt_d         = cnt_q + 3'd1;
                    end
                end
            end

            HOLD: begin
                if (outFire) begin
                    for (int k = 0; k < NUM_CHAN; k++) begin
                        conv_d[k*BIT_WIDTH +: BIT_WIDTH] = slot_q[k];
                    end
                    outValid_d = 1'b1;
                    state_d    = FILL;
                end
            end

            default: begin
                state_d = FILL;
                cnt_d   = 3'd0;
            end
        endcase

        if (frameBreak || missingLast) begin
            err_d = 1'b1;
        end

        inReady_d = (state_d == FILL);
    end

    // State and data registers.
    // Reset throws away any partial group and any held output. in_ready is
    // held low during reset and rises on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            cnt_q      <= 3'd0;
            for (int k = 0; k < NUM_CHAN; k++) begin
                slot_q[k] <= '0;
            end
            conv_q     <= '0;
            outValid_q <= 1'b0;
            inReady_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            conv_q     <= conv_d;
            outValid_q <= outValid_d;
            inReady_q  <= inReady_d;
            err_q      <= err_d;
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign conv      = conv_q;

`ifdef CHAN_LAST_CHECK_EN
    assign err = err_q;
`else
    // With the check disabled, err is a constant 0. err_q still exists (it
    // never sets), and this tap marks it as intentionally unused.
    logic unusedErr;
    assign unusedErr = err_q;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_channel_pack_6.sv
// ============================================================================
// tb_channel_pack_6
// ----------------------------------------------------------------------------
// Scoreboard bench for channel_pack_6.
//
// When stimulus issues a group, it pushes the expected packed word into expQ.
// A separate monitor runs on the falling edge. Whenever the DUT hands over a
// group (out_valid && out_ready), the monitor pops the oldest expected group
// and compares it. While a group is stalled, the monitor also checks that
// conv and out_valid do not change.
// ============================================================================
module tb_channel_pack_6;

    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [6*BW-1:0] conv;
    logic          err;

    logic [47:0]   expQ [$];
    logic [47:0]   expVal;
    logic [47:0]   prevConv = '0;
    bit            prevStall = 1'b0;
    bit            rndDone = 1'b0;
    int            compared = 0;
    int            mismatched = 0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    channel_pack_6 #(.BIT_WIDTH(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .conv      (conv),
        .err       (err)
    );

    // One comparison: bump the counters, and report the values on a miss.
    task automatic checkOutput(input string name, input logic [47:0] got, input logic [47:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Drive one word and wait (bounded) until the DUT accepts it. Inputs change
    // 1 ns after the rising edge. Readiness is sampled on the falling edge.
    task automatic sendWord(input logic [7:0] d, input logic last, output int waits);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 500) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL acceptTimeout: got in_ready=0 after %0d cycles, expected 1", waits);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Issue a six-word group. If push is set, the expected packed group goes
    // into the scoreboard first. in_last is raised on word lastPos. When gaps
    // is set, idle cycles are inserted at random between words.
    task automatic applyStimulus(input logic [47:0] g, input int lastPos, input bit push,
                                 input bit gaps, output int waits);
        int w;
        waits = 0;
        if (push) expQ.push_back(g);
        for (int k = 0; k < 6; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            sendWord(g[k*8 +: 8], (k == lastPos), w);
            waits += w;
            if (k == lastPos && lastPos != 5) break;
        end
    endtask

    // Wait (bounded) until the scoreboard has drained.
    task automatic waitDrain(input string name);
        int b = 0;
        while (expQ.size() != 0 && b < 3000) begin
            @(posedge clk);
            #1;
            b++;
        end
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: got %0d groups pending, expected 0", name, expQ.size());
        end
    endtask

    // Monitor. On each falling edge outside reset, it checks stall stability
    // and pops/compares every group the DUT hands over.
    always @(negedge clk) begin
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stallConv", conv, prevConv);
                checkOutput("stallValid", {47'd0, out_valid}, 48'd1);
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpectedGroup: got %h, expected no group", conv);
                end else begin
                    expVal = expQ.pop_front();
                    checkOutput("group", conv, expVal);
                end
            end
            prevStall = out_valid && !out_ready;
            prevConv  = conv;
        end
    end

    // Global watchdog, so that the run always ends.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waits;
        int total;
        logic [47:0] g;

        // Reset values.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstValid", {47'd0, out_valid}, 48'd0);
        checkOutput("rstReady", {47'd0, in_ready}, 48'd0);
        checkOutput("rstConv", conv, 48'd0);
        checkOutput("rstErr", {47'd0, err}, 48'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("postRstReady", {47'd0, in_ready}, 48'd1);
        checkOutput("postRstValid", {47'd0, out_valid}, 48'd0);

        // Test 1: one group 0x01..0x06 with the output always ready.
        $display("[TB] test 1: single group");
        out_ready = 1'b1;
        applyStimulus(48'h060504030201, 5, 1'b1, 1'b0, waits);
        checkOutput("t1NoStall", waits, 48'd0);
        checkOutput("t1Valid", {47'd0, out_valid}, 48'd1);
        checkOutput("t1Conv", conv, 48'h060504030201);
        repeat (2) @(posedge clk);
        #1;

        // Test 2: the output is blocked, so the second group parks in HOLD.
        $display("[TB] test 2: double buffering");
        out_ready = 1'b0;
        applyStimulus(48'h161514131211, 5, 1'b1, 1'b0, waits);
        applyStimulus(48'h262524232221, 5, 1'b1, 1'b0, waits);
        checkOutput("t2ReadyLow", {47'd0, in_ready}, 48'd0);
        checkOutput("t2Held", conv, 48'h161514131211);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t2StillHeld", conv, 48'h161514131211);
        checkOutput("t2StillLow", {47'd0, in_ready}, 48'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t2SecondConv", conv, 48'h262524232221);
        checkOutput("t2ReadyBack", {47'd0, in_ready}, 48'd1);
        checkOutput("t2SecondValid", {47'd0, out_valid}, 48'd1);
        @(posedge clk);
        #1;
        checkOutput("t2Drained", {47'd0, out_valid}, 48'd0);

        // Test 3: four groups streamed back to back, with no stall allowed.
        $display("[TB] test 3: streaming");
        total = 0;
        applyStimulus(48'h666564636261, 5, 1'b1, 1'b0, waits); total += waits;
        applyStimulus(48'h767574737271, 5, 1'b1, 1'b0, waits); total += waits;
        applyStimulus(48'h868584838281, 5, 1'b1, 1'b0, waits); total += waits;
        applyStimulus(48'h969594939291, 5, 1'b1, 1'b0, waits); total += waits;
        checkOutput("t3NoStall", total, 48'd0);
        waitDrain("t3Drain");

        // Test 4: reset in the middle of a group. The partial group must never
        // appear at the output.
        $display("[TB] test 4: reset mid-group");
        sendWord(8'h51, 1'b0, waits);
        sendWord(8'h52, 1'b0, waits);
        sendWord(8'h53, 1'b0, waits);
        rst = 1'b1;
        #2;
        checkOutput("t4RstValid", {47'd0, out_valid}, 48'd0);
        checkOutput("t4RstReady", {47'd0, in_ready}, 48'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("t4PostValid", {47'd0, out_valid}, 48'd0);
        applyStimulus(48'hA6A5A4A3A2A1, 5, 1'b1, 1'b0, waits);
        checkOutput("t4Conv", conv, 48'hA6A5A4A3A2A1);
        waitDrain("t4Drain");

        // Test 5: framing check on in_last.
`ifdef CHAN_LAST_CHECK_EN
        $display("[TB] test 5: early in_last discards group");
        applyStimulus(48'h000034333231, 3, 1'b0, 1'b0, waits);
        checkOutput("t5ErrSet", {47'd0, err}, 48'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5NoOutput", {47'd0, out_valid}, 48'd0);
        applyStimulus(48'h464544434241, 5, 1'b1, 1'b0, waits);
        checkOutput("t5CleanConv", conv, 48'h464544434241);
        checkOutput("t5ErrSticky", {47'd0, err}, 48'd1);
`else
        $display("[TB] test 5: in_last ignored");
        expQ.push_back(48'h363534333231);
        for (int k = 0; k < 6; k++) begin
            sendWord(8'h31 + 8'(k), (k == 3), waits);
        end
        checkOutput("t5Conv", conv, 48'h363534333231);
        checkOutput("t5ErrZero", {47'd0, err}, 48'd0);
`endif
        waitDrain("t5Drain");

        // Test 6: random data, with random gaps on the input and random
        // throttling of out_ready.
        $display("[TB] test 6: throttled random traffic");
        rndDone = 1'b0;
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    for (int k = 0; k < 6; k++) begin
                        g[k*8 +: 8] = 8'($urandom_range(0, 255));
                    end
                    applyStimulus(g, 5, 1'b1, 1'b1, waits);
                end
                waitDrain("t6Drain");
                rndDone = 1'b1;
            end
            begin
                while (!rndDone) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 1) == 1);
                end
                out_ready = 1'b1;
            end
        join

        repeat (3) @(posedge clk);
        #1;
        checkOutput("finalQueueEmpty", 48'(expQ.size()), 48'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/channel_pack_6.md
# channel_pack_6

Serial-to-parallel packer that collects six per-channel convolution results and presents them as one packed bus to the six-input channel adder tree. It sits between the per-channel convolution engine, which emits one channel result per transfer, and the combinational `add_channel_6` summation stage. It is double-buffered, so a new group can be collected while the previous packed group is still held for the downstream consumer. Valid/ready handshakes are used on both sides.

## Interface
- `BIT_WIDTH`, default 8: width of one channel result, in two's-complement.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous reset, active-high.
- `in_valid` input 1: the upstream channel result is valid.
- `in_ready` output 1: the block accepts a word on the cycle where `in_valid && in_ready`.
- `in_data` input BIT_WIDTH: the channel result. Words arrive in channel order 0..5.
- `in_last` input 1: marks channel 5 of a group. It is only used when `CHAN_LAST_CHECK_EN` is defined.
- `out_valid` output 1: `conv` holds a complete group.
- `out_ready` input 1: the downstream stage takes the group on the cycle where `out_valid && out_ready`.
- `conv` output 6*BIT_WIDTH: the packed group. Channel k sits in `conv[(k+1)*BIT_WIDTH-1 : k*BIT_WIDTH]`.
- `err` output 1: sticky framing error flag.

## Operation
- The collect buffer holds six BIT_WIDTH registers plus a 3-bit channel counter `cnt` (0..5). The output register holds `conv` and `out_valid`.
- The state machine has two states:
  - FILL: `in_ready`=1.
  - HOLD: `in_ready`=0. In this state a full group waits in the collect buffer.
- In FILL, an accepted word is written to slot `cnt`, then `cnt` increments.
- On accept with `cnt`==5:
  - If the output slot is free (`!out_valid || out_ready` in that cycle), slots 0..4 plus `in_data` load into `conv` on the same edge. `out_valid` becomes 1, `cnt` becomes 0, and the state stays FILL.
  - Otherwise the sixth word is stored in slot 5, `cnt` becomes 0, and the state goes to HOLD.
- In HOLD, when `out_valid && out_ready`, the collect buffer loads into `conv`, `out_valid` stays 1, and the state goes back to FILL.
- When `out_valid && out_ready` and no new group is loading, `out_valid` clears on the next edge. `conv` keeps its last value.
- A simultaneous output drain and sixth-word accept produces back-to-back groups with no bubble.
- Data passes through unmodified: no arithmetic, sign extension or saturation. Those belong to the adder tree.
- `conv` is stable whenever `out_valid`=1 and `out_ready`=0.

## Timing
- Reset (asynchronous, while `rst`=1):
  - State FILL, `cnt`=0, all slots 0, `conv`=0, `out_valid`=0, `err`=0.
  - `in_ready` is forced to 0 while `rst` is high and returns to 1 on the first cycle after deassertion.
- Latency: `out_valid` rises on the clock edge that accepts channel 5, so `conv` is visible the cycle after that accept.
- Throughput: one word per cycle sustained, which is six cycles per group, as long as the downstream side drains at least once every six cycles.
- `in_ready` is a registered state decode and does not depend combinationally on `out_ready`.
- Reset mid-group discards the partial group and any held output. No output appears for it.

## Configuration
- `CHAN_LAST_CHECK_EN` defined:
  - `in_last`=1 accepted with `cnt`≠5: `err` sets and the partial group is discarded (`cnt`→0, no output).
  - `in_last`=0 accepted with `cnt`==5: `err` sets and the group is still emitted.
  - `err` clears only on reset.
- `CHAN_LAST_CHECK_EN` undefined: `in_last` is ignored and `err` is tied to 0.

## Test plan
- Reset, then 6 back-to-back words 0x01..0x06 with `out_ready`=1 → one cycle after the 6th accept, `out_valid`=1 and `conv`=0x060504030201. `in_ready` never drops.
- `out_ready`=0, send two groups (0x11..0x16, then 0x21..0x26) → the first group is held on `conv`, and `in_ready`=0 after the 12th accept. Raise `out_ready` → the next edge shows `conv`=0x262524232221 and `in_ready`=1.
- Continuous stream of 4 groups with `out_ready`=1 → 4 groups are output on consecutive 6-cycle boundaries with no stall, and byte order is preserved.
- Assert `rst` after 3 words of a group, then send 6 words 0xA1..0xA6 → the output is 0xA6A5A4A3A2A1 only, and `out_valid` is 0 during and right after reset.
- `CHAN_LAST_CHECK_EN` defined: `in_last`=1 on word 4 of 0x31..0x34 → `err`=1 and no output. The next clean 6-word group 0x41..0x46 is emitted correctly, and `err` stays 1.
- Random `in_valid`/`out_ready` throttling over 200 groups → the scoreboard matches every group in order, and `conv` is stable while stalled.
